// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches on an in-order imem port,
// buffers responses and pushes {pc, instr} entries into the downstream instruction FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fifo_wr_en,
  output logic [63:0] fifo_wr_data,
  input  logic        fifo_full
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   MAX_SUM  = (CW + 1)'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] buf_count_q, buf_count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [63:0]   buf_mem [MAX_OUTSTANDING];

  logic accept;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Counters are bounded by MAX_OUTSTANDING, so the sum always fits in CW+1 bits.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, in_flight_q} + {1'b0, buf_count_q}) < MAX_SUM);
  assign imem_req_addr  = fetch_pc_q;
  assign fifo_wr_en     = !rst && !redirect_valid && (buf_count_q != '0) && !fifo_full;
  assign fifo_wr_data   = (buf_count_q != '0) ? buf_mem[head_q] : '0;

  assign accept = imem_req_valid && imem_req_ready;
  assign push   = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid && !rst;
  assign pop    = fifo_wr_en;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    in_flight_d = in_flight_q;
    drop_cnt_d  = drop_cnt_q;
    buf_count_d = buf_count_q;
    head_d      = head_q;
    tail_d      = tail_q;

    case ({accept, imem_resp_valid})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase

    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;

    if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;

    if (push) begin
      tail_d    = ptr_inc(tail_q);
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) head_d = ptr_inc(head_q);

    case ({push, pop})
      2'b10:   buf_count_d = buf_count_q + 1'b1;
      2'b01:   buf_count_d = buf_count_q - 1'b1;
      default: buf_count_d = buf_count_q;
    endcase

    // Every request still outstanding once this cycle ends belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d  = {redirect_pc[31:2], 2'b00};
      resp_pc_d   = {redirect_pc[31:2], 2'b00};
      drop_cnt_d  = in_flight_d;
      buf_count_d = '0;
      head_d      = '0;
      tail_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      buf_count_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      buf_count_q <= buf_count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // NOTE: buffer storage is not reset; buf_count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) buf_mem[tail_q] <= {resp_pc_q, imem_resp_data};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order imem model with programmable latency
// feeds the DUT while FIFO writes and accepted requests are logged and checked.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fifo_wr_en;
  logic [63:0] fifo_wr_data;
  logic        fifo_full;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h8000_0000), .MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_full      (fifo_full)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int lat      = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_addr[$];
  logic [63:0] wr_log[$];
  int          wr_cyc[$];
  int          resp_cyc[$];

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_wr_en;
  logic [63:0] s_wr_data;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // One clock cycle: drive the imem response, sample outputs mid-cycle, log handshakes.
  task automatic tick();
    if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(pend_addr[0]);
      resp_cyc.push_back(cycle);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_wr_en     = fifo_wr_en;
    s_wr_data   = fifo_wr_data;
    if (imem_req_valid && imem_req_ready) begin
      acc_addr.push_back(imem_req_addr);
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cycle + lat);
    end
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_wr_data);
      wr_cyc.push_back(cycle);
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    wr_log.delete();
    wr_cyc.delete();
    resp_cyc.delete();
  endtask

  task automatic do_reset();
    pend_addr.delete();
    pend_due.delete();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fifo_full      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b1;
    redirect_valid = 1'b0;
    fifo_full = 1'b0;
    tick();
    tick();
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%b exp=0", s_req_valid);
    end
    checks++;
    if (s_wr_en !== 1'b0) begin
      failures++; $display("FAIL reset_wr_en got=%b exp=0", s_wr_en);
    end
    rst = 1'b0;
    clear_logs();
    tick();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
      failures++; $display("FAIL post_reset_req got=%b/%h exp=1/80000000", s_req_valid, s_req_addr);
    end
    checks++;
    if (s_wr_en !== 1'b0 || s_wr_data !== 64'h0) begin
      failures++; $display("FAIL post_reset_wr got=%b/%h exp=0/0", s_wr_en, s_wr_data);
    end
  endtask

  task automatic test_stream();
    imem_req_ready = 1'b1;
    lat = 1;
    do_reset();
    repeat (12) tick();
    checks++;
    if (wr_log.size() < 4 || acc_addr.size() < 4) begin
      failures++; $display("FAIL stream_count got=%0d/%0d exp>=4", wr_log.size(), acc_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] pc;
        pc = 32'h8000_0000 + 32'(4 * k);
        checks++;
        if (acc_addr[k] !== pc) begin
          failures++; $display("FAIL stream_addr%0d got=%h exp=%h", k, acc_addr[k], pc);
        end
        checks++;
        if (wr_log[k] !== {pc, instr_of(pc)}) begin
          failures++; $display("FAIL stream_data%0d got=%h exp=%h", k, wr_log[k], {pc, instr_of(pc)});
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (wr_cyc[k] !== resp_cyc[k] + 1) begin
          failures++; $display("FAIL stream_latency%0d got=%0d exp=%0d", k, wr_cyc[k], resp_cyc[k] + 1);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    imem_req_ready = 1'b1;
    lat = 1;
    do_reset();
    fifo_full = 1'b1;
    repeat (10) tick();
    checks++;
    if (acc_addr.size() != 2) begin
      failures++; $display("FAIL full_accepts got=%0d exp=2", acc_addr.size());
    end
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++; $display("FAIL full_stall got=%b exp=0", s_req_valid);
    end
    checks++;
    if (wr_log.size() != 0) begin
      failures++; $display("FAIL full_no_write got=%0d exp=0", wr_log.size());
    end
    fifo_full = 1'b0;
    repeat (6) tick();
    checks++;
    if (wr_log.size() < 2 || acc_addr.size() < 3) begin
      failures++; $display("FAIL drain_count got=%0d/%0d exp>=2/3", wr_log.size(), acc_addr.size());
    end else begin
      checks++;
      if (wr_log[0] !== {32'h8000_0000, instr_of(32'h8000_0000)} ||
          wr_log[1] !== {32'h8000_0004, instr_of(32'h8000_0004)}) begin
        failures++; $display("FAIL drain_data got=%h,%h exp pcs 80000000,80000004", wr_log[0], wr_log[1]);
      end
      checks++;
      if (wr_cyc[1] !== wr_cyc[0] + 1) begin
        failures++; $display("FAIL drain_consecutive got=%0d exp=%0d", wr_cyc[1], wr_cyc[0] + 1);
      end
      checks++;
      if (acc_addr[2] !== 32'h8000_0008) begin
        failures++; $display("FAIL drain_resume got=%h exp=80000008", acc_addr[2]);
      end
    end
  endtask

  task automatic test_redirect();
    imem_req_ready = 1'b1;
    lat = 5;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (s_req_valid !== 1'b0 || acc_addr.size() != 2) begin
      failures++; $display("FAIL redir_no_issue got=%b/%0d exp=0/2", s_req_valid, acc_addr.size());
    end
    clear_logs();
    repeat (16) tick();
    checks++;
    if (wr_log.size() < 1 || acc_addr.size() < 1) begin
      failures++; $display("FAIL redir_count got=%0d/%0d exp>=1", wr_log.size(), acc_addr.size());
    end else begin
      checks++;
      if (acc_addr[0] !== 32'h0000_1000) begin
        failures++; $display("FAIL redir_addr got=%h exp=00001000", acc_addr[0]);
      end
      checks++;
      if (wr_log[0] !== {32'h0000_1000, instr_of(32'h0000_1000)}) begin
        failures++; $display("FAIL redir_data got=%h exp=%h", wr_log[0], {32'h0000_1000, instr_of(32'h0000_1000)});
      end
    end
  endtask

  task automatic test_back_to_back();
    imem_req_ready = 1'b1;
    lat = 2;
    do_reset();
    fifo_full = 1'b1;
    repeat (3) tick();
    // Response for the second request lands now while the first sits buffered.
    fifo_full      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (s_wr_en !== 1'b0 || imem_resp_valid !== 1'b1) begin
      failures++; $display("FAIL collide_wr got=%b resp=%b exp=0 resp=1", s_wr_en, imem_resp_valid);
    end
    clear_logs();
    tick();
    checks++;
    if (s_wr_en !== 1'b0) begin
      failures++; $display("FAIL collide_buf_empty got=%b exp=0", s_wr_en);
    end
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_2000) begin
      failures++; $display("FAIL collide_req got=%b/%h exp=1/00002000", s_req_valid, s_req_addr);
    end
    repeat (6) tick();
    checks++;
    if (wr_log.size() < 1) begin
      failures++; $display("FAIL collide_count got=0 exp>=1");
    end else if (wr_log[0] !== {32'h0000_2000, instr_of(32'h0000_2000)}) begin
      failures++; $display("FAIL collide_data got=%h exp=%h", wr_log[0], {32'h0000_2000, instr_of(32'h0000_2000)});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    imem_req_ready = 1'b1;
    lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    repeat (10) tick();
    checks++;
    if (wr_log.size() < 3 || acc_addr.size() < 3) begin
      failures++; $display("FAIL wrap_count got=%0d/%0d exp>=3", wr_log.size(), acc_addr.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (acc_addr[k] !== exp_pc[k]) begin
          failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, acc_addr[k], exp_pc[k]);
        end
        checks++;
        if (wr_log[k] !== {exp_pc[k], instr_of(exp_pc[k])}) begin
          failures++; $display("FAIL wrap_data%0d got=%h exp=%h", k, wr_log[k], {exp_pc[k], instr_of(exp_pc[k])});
        end
      end
    end
  endtask

  task automatic test_stall_and_reset();
    int c_rel;
    lat = 1;
    imem_req_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/80000000", k, s_req_valid, s_req_addr);
      end
    end
    imem_req_ready = 1'b1;
    repeat (5) tick();
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b1;
    tick();
    checks++;
    if (s_req_valid !== 1'b0 || s_wr_en !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b/%b exp=0/0", s_req_valid, s_wr_en);
    end
    rst = 1'b0;
    clear_logs();
    c_rel = cycle;
    tick();
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000 ||
        s_wr_en !== 1'b0 || s_wr_data !== 64'h0) begin
      failures++; $display("FAIL midrst_release got=%b/%h/%b/%h exp=1/80000000/0/0",
                           s_req_valid, s_req_addr, s_wr_en, s_wr_data);
    end
    repeat (8) tick();
    checks++;
    if (wr_log.size() < 1) begin
      failures++; $display("FAIL midrst_count got=0 exp>=1");
    end else if (wr_log[0] !== {32'h8000_0000, instr_of(32'h8000_0000)} || wr_cyc[0] < c_rel + 2) begin
      failures++; $display("FAIL midrst_first_write got=%h@%0d exp=%h@>=%0d",
                           wr_log[0], wr_cyc[0], {32'h8000_0000, instr_of(32'h8000_0000)}, c_rel + 2);
    end
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    fifo_full       = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_fifo_full();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_stall_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
